// File: rtl/accumulator_drain.sv
// ---------------------------------------------------------------------------
// accumulator_drain
//
// Walks a contiguous range of accumulator vectors, reads each one through the
// accumulator read port and requantizes every lane to a narrow signed value:
// rounding right shift, optional ReLU, then saturation. Each result vector is
// presented on a valid/ready handshake. A Start pulse launches a drain; Done
// pulses for one cycle once the range has been fully handed off.
//
// Optional feature macro: ACC_DRAIN_ROUND_EN
//   defined     -> round-half-up (adds 2^(shift-1) before shifting, shift>0)
//   not defined -> plain arithmetic shift (truncation toward -infinity)
//
// Ports
//   i_clk                   clock, rising edge
//   i_async_rst             asynchronous active-high reset
//   i_sync_rst              synchronous active-high reset (same effect)
//   i_start                 one-cycle drain request (ignored while busy)
//   i_base_vector           first vector address, sampled on accepted start
//   i_num_vectors           number of vectors, sampled on accepted start
//   i_shift                 right-shift amount, sampled on accepted start
//   i_relu_en               clamp negatives to zero, sampled on accepted start
//   o_read_vector_selector  accumulator read address (valid during ISSUE)
//   i_read_vector           accumulator read data, one cycle after selector
//   o_out_vector            requantized result vector
//   o_out_valid             o_out_vector holds a result
//   i_out_ready             sink accepts o_out_vector
//   o_busy                  drain in progress
//   o_done                  one-cycle pulse at end of drain
// ---------------------------------------------------------------------------
module accumulator_drain #(
    parameter int NO_ACC_PER_VECTOR = 256,
    parameter int ACC_WIDTH         = 32,
    parameter int SELECTOR_WIDTH    = 12,
    parameter int OUT_WIDTH         = 8,
    parameter int SHIFT_WIDTH       = 5
) (
    input  logic                                      i_clk,
    input  logic                                      i_async_rst,
    input  logic                                      i_sync_rst,
    input  logic                                      i_start,
    input  logic [SELECTOR_WIDTH-1:0]                 i_base_vector,
    input  logic [SELECTOR_WIDTH-1:0]                 i_num_vectors,
    input  logic [SHIFT_WIDTH-1:0]                    i_shift,
    input  logic                                      i_relu_en,
    output logic [SELECTOR_WIDTH-1:0]                 o_read_vector_selector,
    input  logic [NO_ACC_PER_VECTOR*ACC_WIDTH-1:0]    i_read_vector,
    output logic [NO_ACC_PER_VECTOR*OUT_WIDTH-1:0]    o_out_vector,
    output logic                                      o_out_valid,
    input  logic                                      i_out_ready,
    output logic                                      o_busy,
    output logic                                      o_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // Saturation bounds expressed in the widened (ACC_WIDTH+1) domain.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t                                 r_state;
    logic [SELECTOR_WIDTH-1:0]              r_address;
    logic [SELECTOR_WIDTH-1:0]              r_remaining;
    logic [SHIFT_WIDTH-1:0]                 r_shift;
    logic                                   r_relu_en;
    logic [NO_ACC_PER_VECTOR*OUT_WIDTH-1:0] w_requant;

    // Requantize one signed lane: round, arithmetic shift, ReLU, saturate.
    function automatic logic [OUT_WIDTH-1:0] f_requant(
        input logic [ACC_WIDTH-1:0]   lane,
        input logic [SHIFT_WIDTH-1:0] shift,
        input logic                   relu_en
    );
        logic signed [ACC_WIDTH:0] v_round;
        logic signed [ACC_WIDTH:0] v_sum;
        logic signed [ACC_WIDTH:0] v_shifted;
        logic signed [ACC_WIDTH:0] v_relu;
        logic signed [ACC_WIDTH:0] v_sat;
        v_round = '0;
`ifdef ACC_DRAIN_ROUND_EN
        if (shift != '0) begin
            v_round = $signed({{ACC_WIDTH{1'b0}}, 1'b1} << (shift - SHIFT_WIDTH'(1)));
        end else begin
            v_round = '0;
        end
`endif
        // One extra bit of headroom makes the rounding add overflow-free.
        v_sum = $signed({lane[ACC_WIDTH-1], lane}) + v_round;
        if ({{(32-SHIFT_WIDTH){1'b0}}, shift} >= 32'(ACC_WIDTH)) begin
            v_shifted = lane[ACC_WIDTH-1] ? '1 : '0;
        end else begin
            v_shifted = v_sum >>> shift;
        end
        if (relu_en && v_shifted[ACC_WIDTH]) begin
            v_relu = '0;
        end else begin
            v_relu = v_shifted;
        end
        if (v_relu > SAT_MAX) begin
            v_sat = SAT_MAX;
        end else if (v_relu < SAT_MIN) begin
            v_sat = SAT_MIN;
        end else begin
            v_sat = v_relu;
        end
        f_requant = v_sat[OUT_WIDTH-1:0];
    endfunction

    // One requantizer per lane, fed straight from the read port.
    genvar g;
    generate
        for (g = 0; g < NO_ACC_PER_VECTOR; g++) begin : g_lane
            assign w_requant[g*OUT_WIDTH +: OUT_WIDTH] =
                f_requant(i_read_vector[g*ACC_WIDTH +: ACC_WIDTH], r_shift, r_relu_en);
        end
    endgenerate

    // Drain FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            r_state                <= S_IDLE;
            r_address              <= '0;
            r_remaining            <= '0;
            r_shift                <= '0;
            r_relu_en              <= 1'b0;
            o_read_vector_selector <= '0;
            o_out_vector           <= '0;
            o_out_valid            <= 1'b0;
            o_busy                 <= 1'b0;
            o_done                 <= 1'b0;
        end else if (i_sync_rst) begin
            r_state                <= S_IDLE;
            r_address              <= '0;
            r_remaining            <= '0;
            r_shift                <= '0;
            r_relu_en              <= 1'b0;
            o_read_vector_selector <= '0;
            o_out_vector           <= '0;
            o_out_valid            <= 1'b0;
            o_busy                 <= 1'b0;
            o_done                 <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shift   <= i_shift;
                        r_relu_en <= i_relu_en;
                        if (i_num_vectors == '0) begin
                            // Empty range completes without ever going busy.
                            o_done <= 1'b1;
                        end else begin
                            r_address              <= i_base_vector;
                            r_remaining            <= i_num_vectors;
                            o_read_vector_selector <= i_base_vector;
                            o_busy                 <= 1'b1;
                            r_state                <= S_ISSUE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // Selector is already on the port; data returns next cycle.
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    o_out_vector <= w_requant;
                    o_out_valid  <= 1'b1;
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (o_out_valid && i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_remaining <= r_remaining - SELECTOR_WIDTH'(1);
                        if (r_remaining == SELECTOR_WIDTH'(1)) begin
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            // Address wraps naturally at 2^SELECTOR_WIDTH.
                            r_address              <= r_address + SELECTOR_WIDTH'(1);
                            o_read_vector_selector <= r_address + SELECTOR_WIDTH'(1);
                            r_state                <= S_ISSUE;
                        end
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_drain.sv
// ---------------------------------------------------------------------------
// tb_accumulator_drain
//
// Directed bench for accumulator_drain. A transaction-level model (queue of
// expected vectors, requantization by integer floor division) is compared
// against the DUT on every cycle OutValid is high; hand-computed literals pin
// selectors, lane values and cycle counts of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_accumulator_drain;

    localparam int N   = 256;
    localparam int AW  = 32;
    localparam int SW  = 12;
    localparam int OW  = 8;
    localparam int SHW = 5;

    logic              clk = 1'b0;
    logic              async_rst;
    logic              sync_rst = 1'b0;
    logic              start = 1'b0;
    logic [SW-1:0]     base_vector = '0;
    logic [SW-1:0]     num_vectors = '0;
    logic [SHW-1:0]    shift = '0;
    logic              relu_en = 1'b0;
    logic [SW-1:0]     sel;
    logic [N*AW-1:0]   read_vector = '0;
    logic [N*OW-1:0]   out_vector;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int done_expected = 0;

    typedef struct {
        int addr;
        int shift;
        bit relu;
    } exp_t;

    typedef struct {
        int addr;
        int lane[4];
    } seen_t;

    exp_t  exp_q[$];
    seen_t seen_q[$];
    int    ovr[int];

    accumulator_drain #(
        .NO_ACC_PER_VECTOR(N),
        .ACC_WIDTH(AW),
        .SELECTOR_WIDTH(SW),
        .OUT_WIDTH(OW),
        .SHIFT_WIDTH(SHW)
    ) dut (
        .i_clk(clk),
        .i_async_rst(async_rst),
        .i_sync_rst(sync_rst),
        .i_start(start),
        .i_base_vector(base_vector),
        .i_num_vectors(num_vectors),
        .i_shift(shift),
        .i_relu_en(relu_en),
        .o_read_vector_selector(sel),
        .i_read_vector(read_vector),
        .o_out_vector(out_vector),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_busy(busy),
        .o_done(done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Accumulator lane contents: overrides for directed lanes, else a pattern.
    function automatic int acc_lane(int addr, int lane);
        int v;
        if (ovr.exists(addr * N + lane)) return ovr[addr * N + lane];
        v = ((addr * 37 + lane * 1013) % 4001) - 2000;
        if (lane % 16 == 5) v = v * 100000;
        return v;
    endfunction

    function automatic logic [N*AW-1:0] build_vec(int addr);
        logic [N*AW-1:0] v;
        for (int l = 0; l < N; l++) v[l*AW +: AW] = acc_lane(addr, l);
        return v;
    endfunction

    // Requantization from first principles: floor(x / 2^s), clamp.
    function automatic int requant(longint v, int s, bit relu);
        longint d;
        longint r;
        longint q;
        d = 1;
        for (int k = 0; k < s; k++) d = d * 2;
        r = v;
`ifdef ACC_DRAIN_ROUND_EN
        if (s > 0) r = r + d / 2;
`endif
        q = r / d;
        if ((r % d) != 0 && r < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic logic [N*OW-1:0] model_vec(int addr, int s, bit relu);
        logic [N*OW-1:0] mv;
        for (int l = 0; l < N; l++) mv[l*OW +: OW] = 8'(requant(acc_lane(addr, l), s, relu));
        return mv;
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Accumulator read port: registered read, data one cycle after selector.
    initial forever begin
        @(posedge clk);
        read_vector <= build_vec(int'(sel));
    end

    // Compare process: DUT outputs vs model on every OutValid cycle.
    initial begin : compare_proc
        logic [N*OW-1:0] ev;
        int bad;
        bit prev_done;
        seen_t s;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!async_rst && !sync_rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", out_valid, 0);
                    end else begin
                        ev = model_vec(exp_q[0].addr, exp_q[0].shift, exp_q[0].relu);
                        bad = -1;
                        for (int l = N - 1; l >= 0; l--)
                            if (out_vector[l*OW +: OW] != ev[l*OW +: OW]) bad = l;
                        n_cmp++;
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL out_vector addr %0d lane %0d: got %0d want %0d",
                                     exp_q[0].addr, bad, $signed(out_vector[bad*OW +: OW]),
                                     $signed(ev[bad*OW +: OW]));
                        end
                        chk("selector_while_valid", sel, exp_q[0].addr);
                        if (out_ready) begin
                            s.addr = int'(sel);
                            for (int k = 0; k < 4; k++) s.lane[k] = int'($signed(out_vector[k*OW +: OW]));
                            seen_q.push_back(s);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (prev_done) chk("done_one_cycle", done, 0);
                if (done) done_seen++;
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    task automatic push_range(input int base, input int num, input int sh, input bit relu);
        for (int k = 0; k < num; k++) exp_q.push_back('{addr: (base + k) % 4096, shift: sh, relu: relu});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_outvec_zero"}, (out_vector == '0) ? 1 : 0, 1);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Runs one drain from "just after a rising edge"; returns in the Done cycle.
    task automatic run_drain(input int base, input int num, input int sh, input bit relu,
                             input int stall, input int inject_at, input int exp_cycles,
                             input string tag);
        int n;
        int hold;
        int first_valid;
        push_range(base, num, sh, relu);
        done_expected++;
        base_vector = SW'(base);
        num_vectors = SW'(num);
        shift       = SHW'(sh);
        relu_en     = relu;
        out_ready   = (stall == 0);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; hold = 0; first_valid = -1;
        if (num == 0) begin
            chk({tag, "_busy_low"}, busy, 0);
            chk({tag, "_valid_low"}, out_valid, 0);
        end else begin
            chk({tag, "_sel_first"}, sel, base % 4096);
            chk({tag, "_busy_first"}, busy, 1);
        end
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (n == inject_at) begin
                base_vector = 12'd50;
                num_vectors = 12'd5;
                start       = 1'b1;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = n;
                if (hold < stall) begin
                    out_ready = 1'b0;
                    hold++;
                end else begin
                    out_ready = 1'b1;
                    hold = 0;
                end
            end
            if (!done) chk({tag, "_busy_during"}, busy, 1);
        end
        start = 1'b0;
        chk({tag, "_cycles_to_done"}, n, exp_cycles);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        if (num > 0) chk({tag, "_first_valid_cycle"}, first_valid, 2);
        chk({tag, "_model_drained"}, exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid_seen"}, out_valid, 1);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r0[4];
        int r1[4];
`ifdef ACC_DRAIN_ROUND_EN
        r0 = '{2, -1, 127, -128};
        r1 = '{2, 0, 127, 0};
`else
        r0 = '{1, -2, 127, -128};
        r1 = '{1, 0, 127, 0};
`endif
        ovr[10 * N]  = 5;
        ovr[11 * N]  = -3;
        ovr[12 * N]  = 200;
        ovr[100 * N + 0] = 6;
        ovr[100 * N + 1] = -6;
        ovr[100 * N + 2] = 1000;
        ovr[100 * N + 3] = -100000;

        // Power-on reset, observed before any clock edge.
        async_rst = 1'b0;
        #1 async_rst = 1'b1;
        #1 check_reset("por");
        @(posedge clk); @(posedge clk); #1;
        async_rst = 1'b0;
        idle(2);

        // Asynchronous reset in the middle of a drain.
        push_range(200, 4, 0, 0);
        base_vector = 12'd200; num_vectors = 12'd4; shift = '0; relu_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("async");
        #2 async_rst = 1'b1;
        exp_q.delete();
        #1 check_reset("async_mid");
        @(posedge clk); #1;
        async_rst = 1'b0;
        idle(10);
        chk("async_no_done", done_seen, done_expected);
        chk("async_stays_idle", busy, 0);

        // Synchronous reset in the middle of a drain.
        push_range(200, 4, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("sync");
        sync_rst = 1'b1;
        #1 chk("sync_waits_for_edge", out_valid, 1);
        @(posedge clk); #1;
        exp_q.delete();
        check_reset("sync_mid");
        sync_rst = 1'b0;
        idle(10);
        chk("sync_no_done", done_seen, done_expected);

        // Basic drain, then a wrapping drain started in the Done cycle.
        seen_q.delete();
        run_drain(10, 3, 0, 0, 0, 0, 9, "basic");
        chk("basic_count", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            chk("basic_sel0", seen_q[0].addr, 10);
            chk("basic_sel1", seen_q[1].addr, 11);
            chk("basic_sel2", seen_q[2].addr, 12);
            chk("basic_lane0_v0", seen_q[0].lane[0], 5);
            chk("basic_lane0_v1", seen_q[1].lane[0], -3);
            chk("basic_lane0_v2", seen_q[2].lane[0], 127);
        end
        seen_q.delete();
        run_drain(4095, 2, 1, 0, 0, 0, 6, "wrap");
        chk("wrap_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            chk("wrap_sel0", seen_q[0].addr, 4095);
            chk("wrap_sel1", seen_q[1].addr, 0);
        end
        idle(3);

        // Requantization corner values, ReLU off and on.
        seen_q.delete();
        run_drain(100, 1, 2, 0, 0, 0, 3, "arith_r0");
        chk("arith_r0_count", seen_q.size(), 1);
        if (seen_q.size() == 1)
            for (int k = 0; k < 4; k++) chk($sformatf("arith_r0_lane%0d", k), seen_q[0].lane[k], r0[k]);
        seen_q.delete();
        run_drain(100, 1, 2, 1, 0, 0, 3, "arith_r1");
        chk("arith_r1_count", seen_q.size(), 1);
        if (seen_q.size() == 1)
            for (int k = 0; k < 4; k++) chk($sformatf("arith_r1_lane%0d", k), seen_q[0].lane[k], r1[k]);
        idle(2);

        // Backpressure: five stalled cycles in HOLD for each vector.
        seen_q.delete();
        run_drain(300, 2, 3, 0, 5, 0, 16, "stall");
        chk("stall_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            chk("stall_sel0", seen_q[0].addr, 300);
            chk("stall_sel1", seen_q[1].addr, 301);
        end
        idle(2);

        // Empty range: Done only.
        seen_q.delete();
        run_drain(7, 0, 0, 0, 0, 0, 0, "zero");
        idle(4);
        chk("zero_no_output", seen_q.size(), 0);

        // Start while busy is ignored.
        seen_q.delete();
        run_drain(20, 2, 1, 0, 0, 3, 6, "ignore");
        idle(12);
        chk("ignore_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            chk("ignore_sel0", seen_q[0].addr, 20);
            chk("ignore_sel1", seen_q[1].addr, 21);
        end
        chk("ignore_idle_busy", busy, 0);

        chk("done_total", done_seen, done_expected);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
